// File: rtl/data_mem.sv
// Word-addressed data memory for a core load/store port; clears itself to zero after reset.
// Latency: reads return one cycle after the accepting edge; writes commit at the accepting edge.
// Backpressure: ready is low while the clearing pass runs; requests seen then are ignored.
// Optional feature: define DATA_MEM_ERR_EN for err pulses and misaligned-access rejection.
module data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_en,
    input  logic        data_rd_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        ready,
    output logic        rd_valid,
    output logic        err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_in_q, data_in_d;
    logic            rd_valid_q, rd_valid_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;

    // Offset from the window base; addresses below the base wrap to huge
    // offsets and therefore fall out of range without extra comparison.
    logic [31:0]     offset;
    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic            accept;
    logic            addr_ok;

    assign offset   = data_addr - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[AW+1:2];
    assign accept   = data_en && (state_q == ST_IDLE);

`ifdef DATA_MEM_ERR_EN
    logic err_q, err_d;

    // Misaligned accesses are treated as bad: writes dropped, reads return 0.
    assign addr_ok = in_range && (data_addr[1:0] == 2'b00);
    assign err_d   = accept && !addr_ok;

    // Error pulse register, aligned with the response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Low address bits are simply ignored; only the range matters.
    assign addr_ok = in_range;
    assign err     = 1'b0;
`endif

    // Next-state, memory write port and response generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_in_d  = data_in_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cnt_q;
        mem_wdata  = 32'h0;
        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (data_rd_wr) begin
                        rd_valid_d = 1'b1;
                        data_in_d  = addr_ok ? mem_q[word_idx] : 32'h0;
                    end else if (addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = word_idx;
                        mem_wdata = data_out;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and response registers; reset discards any in-flight read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            data_in_q  <= 32'h0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_in_q  <= data_in_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage array; contents are only meaningful after the clearing pass.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign rd_valid = rd_valid_q;
    assign data_in  = data_in_q;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DATA_MEM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        data_en;
    logic        data_rd_wr;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ready;
    logic        rd_valid;
    logic        err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    data_mem #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_en   (data_en),
        .data_rd_wr(data_rd_wr),
        .data_addr (data_addr),
        .data_out  (data_out),
        .data_in   (data_in),
        .ready     (ready),
        .rd_valid  (rd_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one request, then sample 1 time unit after the edge that takes it.
    task automatic step(input logic en, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata);
        data_en    = en;
        data_rd_wr = rd;
        data_addr  = addr;
        data_out   = wdata;
        @(posedge clk);
        #1;
    endtask

    // Count the clearing pass edge by edge: ready only after the 16th edge.
    task automatic check_init(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check({tag, " ready"}, {31'b0, ready}, {31'b0, (i == DEPTH)});
            check({tag, " no rd_valid"}, {31'b0, rd_valid}, 32'h0);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        data_en    = 1'b0;
        data_rd_wr = 1'b0;
        data_addr  = 32'h0;
        data_out   = 32'h0;
        reset      = 1'b0;

        //            en    rd    addr          wdata         vld   data                          err
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000,               1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_1008, 32'h0,         1'b1, 32'hDEAD_BEEF,               1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF,               1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_1004, 32'h2222_2222, 1'b0, 32'hDEAD_BEEF,               1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h0,         1'b1, 32'h1111_1111,               1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_1004, 32'h0,         1'b1, 32'h2222_2222,               1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_1008, 32'h0,         1'b1, 32'hDEAD_BEEF,               1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         1'b0, 32'hDEAD_BEEF,               1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_1040, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF,               ERR_ON};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0000_0000,               ERR_ON};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0,         1'b1, 32'h1111_1111,               1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_103C, 32'hA5A5_A5A5, 1'b0, 32'h1111_1111,               1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_103C, 32'h0,         1'b1, 32'hA5A5_A5A5,               1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'h0000_1040, 32'h0,         1'b1, 32'h0000_0000,               ERR_ON};
        vecs[14] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000,               ERR_ON};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_1002, 32'h0000_0011, 1'b0, 32'h0000_0000,               ERR_ON};
        vecs[16] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0,         1'b1,
                     ERR_ON ? 32'h1111_1111 : 32'h0000_0011, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 32'h0000_1001, 32'h0,         1'b1,
                     ERR_ON ? 32'h0000_0000 : 32'h0000_0011, ERR_ON};
        vecs[18] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0,         1'b1, 32'h2222_2222,               1'b0};

        // Reset state
        #12;
        check("reset ready",    {31'b0, ready},    32'h0);
        check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
        check("reset err",      {31'b0, err},      32'h0);
        check("reset data_in",  data_in,           32'h0);

        // Release between edges, then the full clearing pass
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_init("init1");

        // Every word reads back as zero, back to back
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, BASE + 32'(4 * i), 32'h0);
            check("clear rd_valid", {31'b0, rd_valid}, 32'h1);
            check("clear data",     data_in,           32'h0);
            check("clear err",      {31'b0, err},      32'h0);
        end

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].en, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_vld});
            check($sformatf("vec%0d data_in", i),  data_in,           vecs[i].exp_data);
            check($sformatf("vec%0d err", i),      {31'b0, err},      {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d ready", i),    {31'b0, ready},    32'h1);
        end
        data_en = 1'b0;

        // Asynchronous reset clears outputs immediately
        reset = 1'b0;
        #1;
        check("async rst data_in", data_in,         32'h0);
        check("async rst ready",   {31'b0, ready},  32'h0);
        #1;
        reset = 1'b1;

        // Reset again at cycle 5 of the clearing pass
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
        end
        #1;
        check("mid-init ready before", {31'b0, ready}, 32'h0);
        reset = 1'b0;
        #1;
        check("mid-init rst ready", {31'b0, ready}, 32'h0);
        reset = 1'b1;

        // Requests during the pass are ignored; the count restarts at full length
        data_en    = 1'b1;
        data_rd_wr = 1'b1;
        data_addr  = BASE;
        check_init("init2");
        data_en = 1'b0;

        // Reset on the edge after a read accept discards the response
        step(1'b1, 1'b0, 32'h0000_1000, 32'h0000_0055);
        data_en    = 1'b1;
        data_rd_wr = 1'b1;
        data_addr  = 32'h0000_1000;
        @(posedge clk);
        reset = 1'b0;
        data_en = 1'b0;
        #1;
        check("inflight rst rd_valid", {31'b0, rd_valid}, 32'h0);
        check("inflight rst data_in",  data_in,           32'h0);
        #2;
        reset = 1'b1;
        check_init("init3");
        step(1'b0, 1'b0, 32'h0, 32'h0);
        check("post-init no rd_valid", {31'b0, rd_valid}, 32'h0);

        // Clearing pass wiped earlier writes
        step(1'b1, 1'b1, 32'h0000_1000, 32'h0);
        check("recleared 1000 vld",  {31'b0, rd_valid}, 32'h1);
        check("recleared 1000 data", data_in,           32'h0);
        step(1'b1, 1'b1, 32'h0000_1008, 32'h0);
        check("recleared 1008 data", data_in,           32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        check("idle rd_valid low", {31'b0, rd_valid}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
